// File: rtl/reg_file_2r1w.sv
// Two-read/one-write register file with byte-lane writes, write-first bypass,
// a sequenced clear sweep and out-of-range address flagging.
//
// state | meaning
// IDLE  | accepts reads/writes; Clr starts a sweep
// CLEAR | zeroes one entry per cycle, all accesses dropped
module reg_file_2r1w #(
  parameter int DATA_WIDTH = 16,
  parameter int DEPTH      = 8,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    wr_en,
  input  logic [ADDR_WIDTH-1:0]   wr_addr,
  input  logic [DATA_WIDTH-1:0]   wr_data,
  input  logic [DATA_WIDTH/8-1:0] wr_byte_en,
  input  logic                    rd_en_a,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_a,
  output logic [DATA_WIDTH-1:0]   rd_data_a,
  output logic                    rd_valid_a,
  input  logic                    rd_en_b,
  input  logic [ADDR_WIDTH-1:0]   rd_addr_b,
  output logic [DATA_WIDTH-1:0]   rd_data_b,
  output logic                    rd_valid_b,
  input  logic                    clr,
  output logic                    busy,
  output logic                    addr_err
);

  localparam int LANES = DATA_WIDTH / 8;
  localparam logic [ADDR_WIDTH:0]   DEPTH_W  = (ADDR_WIDTH + 1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] idx;
  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  accept;
  logic                  wr_ok, a_ok, b_ok, wr_live, err_now;
  logic [DATA_WIDTH-1:0] wr_old, wr_merged, rd_word_a, rd_word_b;

  always_comb begin
    accept  = (state == IDLE) && !clr;
    wr_ok   = {1'b0, wr_addr} < DEPTH_W;
    a_ok    = {1'b0, rd_addr_a} < DEPTH_W;
    b_ok    = {1'b0, rd_addr_b} < DEPTH_W;
    wr_live = accept && wr_en && wr_ok;
    wr_old  = wr_ok ? mem[wr_addr] : '0;
    wr_merged = wr_old;
    for (int k = 0; k < LANES; k++)
      if (wr_byte_en[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
    // Write-first: a same-edge write to the read address is visible immediately.
    rd_word_a = !a_ok ? '0 : (wr_live && wr_addr == rd_addr_a) ? wr_merged : mem[rd_addr_a];
    rd_word_b = !b_ok ? '0 : (wr_live && wr_addr == rd_addr_b) ? wr_merged : mem[rd_addr_b];
    err_now = (wr_en && !wr_ok) || (rd_en_a && !a_ok) || (rd_en_b && !b_ok);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      busy       <= 1'b0;
      addr_err   <= 1'b0;
      rd_data_a  <= '0;
      rd_data_b  <= '0;
      rd_valid_a <= 1'b0;
      rd_valid_b <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      rd_valid_a <= accept && rd_en_a;
      rd_valid_b <= accept && rd_en_b;
      addr_err   <= accept && err_now;
      if (accept && rd_en_a) rd_data_a <= rd_word_a;
      if (accept && rd_en_b) rd_data_b <= rd_word_b;
      case (state)
        IDLE: begin
          if (clr) begin
            state <= CLEAR;
            idx   <= '0;
            busy  <= 1'b1;
          end else if (wr_live) begin
            for (int k = 0; k < LANES; k++)
              if (wr_byte_en[k]) mem[wr_addr][8*k +: 8] <= wr_data[8*k +: 8];
          end
        end
        CLEAR: begin
          mem[idx] <= '0;
          if (idx == LAST_IDX) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: an 8-deep instance for the main scenarios
// and a 6-deep instance for out-of-range addressing.
module tb_reg_file_2r1w;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        wr_en = 0, rd_en_a = 0, rd_en_b = 0, clr = 0;
  logic [2:0]  wr_addr = 0, rd_addr_a = 0, rd_addr_b = 0;
  logic [15:0] wr_data = 0;
  logic [1:0]  wr_byte_en = 0;
  logic [15:0] rd_data_a, rd_data_b;
  logic        rd_valid_a, rd_valid_b, busy, addr_err;

  logic        s_wr_en = 0, s_rd_en_a = 0, s_rd_en_b = 0, s_clr = 0;
  logic [2:0]  s_wr_addr = 0, s_rd_addr_a = 0, s_rd_addr_b = 0;
  logic [15:0] s_wr_data = 0;
  logic [1:0]  s_wr_byte_en = 0;
  logic [15:0] s_rd_data_a, s_rd_data_b;
  logic        s_rd_valid_a, s_rd_valid_b, s_busy, s_addr_err;

  int total = 0;
  int bad = 0;

  reg_file_2r1w #(.DATA_WIDTH(16), .DEPTH(8), .ADDR_WIDTH(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_byte_en(wr_byte_en),
    .rd_en_a(rd_en_a), .rd_addr_a(rd_addr_a), .rd_data_a(rd_data_a), .rd_valid_a(rd_valid_a),
    .rd_en_b(rd_en_b), .rd_addr_b(rd_addr_b), .rd_data_b(rd_data_b), .rd_valid_b(rd_valid_b),
    .clr(clr), .busy(busy), .addr_err(addr_err)
  );

  reg_file_2r1w #(.DATA_WIDTH(16), .DEPTH(6), .ADDR_WIDTH(3)) dut6 (
    .clk(clk), .rst_n(rst_n),
    .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data), .wr_byte_en(s_wr_byte_en),
    .rd_en_a(s_rd_en_a), .rd_addr_a(s_rd_addr_a), .rd_data_a(s_rd_data_a), .rd_valid_a(s_rd_valid_a),
    .rd_en_b(s_rd_en_b), .rd_addr_b(s_rd_addr_b), .rd_data_b(s_rd_data_b), .rd_valid_b(s_rd_valid_b),
    .clr(s_clr), .busy(s_busy), .addr_err(s_addr_err)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [2:0] a, input logic [15:0] d, input logic [1:0] be);
    wr_en = 1; wr_addr = a; wr_data = d; wr_byte_en = be;
    step();
    wr_en = 0;
  endtask

  int cnt;
  int guard;

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data_a", 32'(rd_data_a), 32'h0);
    chk("rst_valid_a", 32'(rd_valid_a), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_addr_err", 32'(addr_err), 32'h0);
    rst_n = 1;
    step();

    // every entry reads 0 after reset, valid one cycle after request
    for (int i = 0; i < 8; i++) begin
      rd_en_a = 1; rd_addr_a = 3'(i);
      rd_en_b = 1; rd_addr_b = 3'(7 - i);
      step();
      chk("t1_data_a", 32'(rd_data_a), 32'h0);
      chk("t1_valid_a", 32'(rd_valid_a), 32'h1);
      chk("t1_data_b", 32'(rd_data_b), 32'h0);
      chk("t1_valid_b", 32'(rd_valid_b), 32'h1);
    end
    rd_en_a = 0; rd_en_b = 0;
    step();
    chk("t1_valid_a_drop", 32'(rd_valid_a), 32'h0);
    chk("t1_valid_b_drop", 32'(rd_valid_b), 32'h0);

    // byte-lane merge
    wr(3'd5, 16'hA5C3, 2'b11);
    wr(3'd5, 16'h1200, 2'b10);
    rd_en_a = 1; rd_addr_a = 3'd5;
    step();
    rd_en_a = 0;
    chk("t2_merge", 32'(rd_data_a), 32'h12C3);
    step();
    chk("t2_hold_data", 32'(rd_data_a), 32'h12C3);

    // write-first bypass on A, plain read on B
    wr(3'd3, 16'h0007, 2'b11);
    wr_en = 1; wr_addr = 3'd2; wr_data = 16'hBEEF; wr_byte_en = 2'b11;
    rd_en_a = 1; rd_addr_a = 3'd2;
    rd_en_b = 1; rd_addr_b = 3'd3;
    step();
    chk("t3_bypass_a", 32'(rd_data_a), 32'hBEEF);
    chk("t3_read_b", 32'(rd_data_b), 32'h0007);
    chk("t3_valid_a", 32'(rd_valid_a), 32'h1);
    chk("t3_valid_b", 32'(rd_valid_b), 32'h1);
    // partial-lane bypass: low lane new, high lane from old 0x12C3
    wr_addr = 3'd5; wr_data = 16'h7788; wr_byte_en = 2'b01;
    rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    step();
    chk("t3_lane_bypass_a", 32'(rd_data_a), 32'h1288);
    chk("t3_lane_bypass_b", 32'(rd_data_b), 32'h1288);
    // no enabled lanes: entry untouched
    wr_addr = 3'd2; wr_data = 16'hFFFF; wr_byte_en = 2'b00;
    rd_en_b = 0;
    rd_addr_a = 3'd2;
    step();
    wr_en = 0;
    chk("t3_be0_bypass", 32'(rd_data_a), 32'hBEEF);
    step();
    rd_en_a = 0;
    chk("t3_be0_stored", 32'(rd_data_a), 32'hBEEF);

    // clear sweep with a colliding write/read on the Clr edge
    for (int i = 0; i < 8; i++) wr(3'(i), 16'hA000 | 16'(i + 1), 2'b11);
    clr = 1; wr_en = 1; wr_addr = 3'd0; wr_data = 16'hFFFF; wr_byte_en = 2'b11;
    rd_en_a = 1; rd_addr_a = 3'd1;
    step();
    cnt = busy ? 1 : 0;
    chk("t4_busy_start", 32'(busy), 32'h1);
    chk("t4_valid_dropped", 32'(rd_valid_a), 32'h0);
    chk("t4_err_dropped", 32'(addr_err), 32'h0);
    step();
    if (busy) cnt++;
    clr = 0;
    guard = 0;
    while (busy && guard < 20) begin
      chk("t4_valid_in_clear", 32'(rd_valid_a), 32'h0);
      step();
      guard++;
      if (busy) cnt++;
    end
    wr_en = 0; rd_en_a = 0;
    chk("t4_busy_cycles", 32'(cnt), 32'd8);
    for (int i = 0; i < 8; i++) begin
      rd_en_a = 1; rd_addr_a = 3'(i);
      step();
      chk("t4_cleared", 32'(rd_data_a), 32'h0);
    end
    rd_en_a = 0;

    // reset in the middle of a sweep
    for (int i = 0; i < 8; i++) wr(3'(i), 16'h5000 | 16'(i + 1), 2'b11);
    rd_en_a = 1; rd_addr_a = 3'd4;
    step();
    rd_en_a = 0;
    chk("t6_pre_read", 32'(rd_data_a), 32'h5005);
    clr = 1;
    step();
    clr = 0;
    step();
    step();
    step();
    chk("t6_busy_before", 32'(busy), 32'h1);
    rst_n = 0;
    #1;
    chk("t6_busy_async", 32'(busy), 32'h0);
    chk("t6_data_a_async", 32'(rd_data_a), 32'h0);
    chk("t6_valid_async", 32'(rd_valid_a), 32'h0);
    rst_n = 1;
    step();
    chk("t6_busy_after", 32'(busy), 32'h0);
    wr(3'd1, 16'h3C3C, 2'b11);
    rd_en_a = 1; rd_addr_a = 3'd1;
    rd_en_b = 1; rd_addr_b = 3'd7;
    step();
    rd_en_a = 0; rd_en_b = 0;
    chk("t6_new_write", 32'(rd_data_a), 32'h3C3C);
    chk("t6_reset_zeroed", 32'(rd_data_b), 32'h0);

    // out-of-range addressing on the 6-deep instance
    for (int i = 0; i < 6; i++) begin
      s_wr_en = 1; s_wr_addr = 3'(i); s_wr_data = 16'h0100 | 16'(i); s_wr_byte_en = 2'b11;
      step();
      chk("t5_inrange_err", 32'(s_addr_err), 32'h0);
    end
    s_wr_addr = 3'd7; s_wr_data = 16'h5555;
    step();
    s_wr_en = 0;
    chk("t5_wr_err", 32'(s_addr_err), 32'h1);
    s_rd_en_a = 1; s_rd_addr_a = 3'd7;
    s_rd_en_b = 1; s_rd_addr_b = 3'd5;
    step();
    s_rd_en_a = 0; s_rd_en_b = 0;
    chk("t5_rd_err", 32'(s_addr_err), 32'h1);
    chk("t5_rd_data", 32'(s_rd_data_a), 32'h0);
    chk("t5_rd_valid", 32'(s_rd_valid_a), 32'h1);
    chk("t5_rd_b", 32'(s_rd_data_b), 32'h0105);
    step();
    chk("t5_err_pulse", 32'(s_addr_err), 32'h0);
    for (int i = 0; i < 6; i++) begin
      s_rd_en_a = 1; s_rd_addr_a = 3'(i);
      step();
      chk("t5_unchanged", 32'(s_rd_data_a), 32'h0100 | 32'(i));
    end
    s_rd_en_a = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
Parametrised register file with one write port and two independent read ports.
- Write side: per-byte write enables.
- Read side: registered reads with write-to-read bypass.
- Housekeeping: a sequenced clear engine and out-of-range address detection.
- Placement: operand storage for datapath blocks that need two operands per cycle, replacing single-port 8x16 storage.

Parameters:
- DATA_WIDTH, 16, word width in bits; must be a multiple of 8.
- DEPTH, 8, number of entries; 2..256, need not be a power of two.
- ADDR_WIDTH, 3, address width; must satisfy 2^ADDR_WIDTH >= DEPTH.

Ports:
- CLK  in  1  clock; all state changes on the rising edge.
- RST  in  1  asynchronous active-low reset.
- WrEn  in  1  write request.
- WrAddr  in  ADDR_WIDTH  write address.
- WrData  in  DATA_WIDTH  write data.
- WrByteEn  in  DATA_WIDTH/8  byte lane enables; bit k enables WrData[8k+7:8k].
- RdEnA  in  1  port A read request.
- RdAddrA  in  ADDR_WIDTH  port A read address.
- RdDataA  out  DATA_WIDTH  port A read data (registered).
- RdValidA  out  1  port A data valid, one-cycle pulse.
- RdEnB, RdAddrB, RdDataB, RdValidB: same as port A, for port B.
- Clr  in  1  start clear sweep (sampled as level).
- Busy  out  1  clear sweep in progress.
- AddrErr  out  1  one-cycle pulse: an accepted access used an address >= DEPTH.

Behaviour:
Reset (RST=0, asynchronous):
- All entries go to 0.
- RdDataA/B=0, RdValidA/B=0, Busy=0, AddrErr=0.
- FSM goes to IDLE, sweep index goes to 0.
- Reset during a sweep aborts it immediately.

FSM states: IDLE, CLEAR.
- IDLE -> CLEAR on an edge with Clr=1; idx<=0, Busy<=1.
- In CLEAR, each edge: entry[idx]<=0, idx<=idx+1.
- When idx==DEPTH-1: entry zeroed, state<=IDLE, Busy<=0.
- Busy is therefore high for exactly DEPTH cycles.
- Clr while in CLEAR is ignored; no restart.

Accepted operations:
- A write or read is accepted only in IDLE on an edge where Clr=0.
- On the Clr edge itself and throughout CLEAR, WrEn/RdEnA/RdEnB are dropped.
- RdValid stays 0 and AddrErr stays 0 while dropped.

Write:
- entry[WrAddr] lane k <= WrData lane k for each WrByteEn[k]=1; other lanes are unchanged.
- WrByteEn=0 performs no write.

Read:
- Latency 1. On an accepted edge with RdEnX=1: RdDataX<=entry[RdAddrX], RdValidX<=1.
- With RdEnX=0, RdDataX holds its value and RdValidX<=0.
- Ports A and B are fully independent; the same address on both ports is legal.

Bypass (write-first):
- Applies when an accepted write and read hit the same in-range address on the same edge.
- RdDataX returns the post-write merged word: enabled lanes from WrData, others from the old entry.

Out of range (address >= DEPTH, reachable only when DEPTH < 2^ADDR_WIDTH):
- Write is dropped.
- Read returns 0 with RdValidX=1.
- AddrErr<=1 for one cycle if any accepted access on that edge was out of range; otherwise AddrErr<=0.

Storage:
- No other state changes the entries; values persist indefinitely.

Test Plan:
1. Reset, then read all 8 addresses on A and B -> every read returns 0x0000 with RdValid high for 1 cycle, one cycle after the request.
2. Write 0xA5C3 to addr 5 with ByteEn=11; next edge write 0x1200 to addr 5 with ByteEn=10; read A addr 5 -> 0x12C3.
3. Same edge: write 0xBEEF to addr 2 (ByteEn=11), RdEnA addr 2, RdEnB addr 3 (which holds 0x0007) -> RdDataA=0xBEEF, RdDataB=0x0007, both valid next cycle.
4. Fill all 8 entries with nonzero data; pulse Clr with WrEn=1, RdEnA=1 on the same edge -> Busy high exactly 8 cycles, write and read dropped, RdValidA=0; afterwards all entries read 0.
5. With DEPTH=6, ADDR_WIDTH=3: write 0x5555 to addr 7, then read addr 7 -> AddrErr pulses on both edges, read data 0x0000 with valid=1, entries 0..5 unchanged.
6. Start a clear sweep, drop RST at sweep cycle 3 and release it -> Busy=0 immediately, all outputs 0; a new write to addr 1 followed by a read of addr 1 returns the written value.
